// File: rtl/data_c_rev_pipe_if.sv
// Valid/ready/data stream bundle shared by both sides of data_c_rev_pipe.
// The interface clock/rst_n ports are carried for the surrounding system only.
interface data_c_rev_pipe_if #(
  parameter int DSIZE = 8
) (
  input logic clock,
  input logic rst_n
);
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (output valid, output data, input ready);
  modport slaver (input valid, input data, output ready);
endinterface

// File: rtl/data_c_rev_pipe.sv
// Fully registered 2-entry skid buffer between a stream slaver and master.
// Optional simulation checks are compiled in with DATA_C_REV_PIPE_CHECK_EN.
//
// state | meaning
// EMPTY | no beat stored, master.valid low
// ONE   | head holds the beat on master.data
// FULL  | head and skid both hold beats, slaver.ready low
module data_c_rev_pipe #(
  parameter int DSIZE = 8
) (
  input  logic              clock,
  input  logic              rst,
  data_c_rev_pipe_if.slaver slaver,
  data_c_rev_pipe_if.master master
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state;
  logic             valid_q;
  logic             ready_q;
  logic [DSIZE-1:0] head;
  logic [DSIZE-1:0] skid;
  logic             in_hs;
  logic             out_hs;

  assign in_hs  = slaver.valid & ready_q;
  assign out_hs = valid_q & master.ready;

  assign slaver.ready = ready_q;
  assign master.valid = valid_q;
  assign master.data  = head;

  // Flags are loaded with the values matching the state being entered.
  always_ff @(posedge clock) begin
    if (rst) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      head    <= '0;
      skid    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          ready_q <= 1'b1;
          if (in_hs) begin
            head    <= slaver.data;
            state   <= ONE;
            valid_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
        end
        ONE: begin
          if (in_hs && !out_hs) begin
            skid    <= slaver.data;
            state   <= FULL;
            valid_q <= 1'b1;
            ready_q <= 1'b0;
          end else if (!in_hs && out_hs) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            if (in_hs) head <= slaver.data;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        FULL: begin
          valid_q <= 1'b1;
          if (out_hs) begin
            head    <= skid;
            state   <= ONE;
            ready_q <= 1'b1;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef DATA_C_REV_PIPE_CHECK_EN
  logic             chk_valid;
  logic             chk_ready;
  logic [DSIZE-1:0] chk_data;

  initial begin
    if ($bits(slaver.data) != $bits(master.data)) begin
      $error("data_c_rev_pipe: slaver/master data widths differ");
      $stop;
    end
  end

  // A beat offered but not taken last cycle must still be offered, unchanged.
  always @(posedge clock) begin
    if (!rst && chk_valid && !chk_ready) begin
      if (!slaver.valid)
        $error("data_c_rev_pipe: slaver.valid dropped without handshake");
      else if (slaver.data != chk_data)
        $error("data_c_rev_pipe: slaver.data changed while stalled");
    end
    chk_valid <= slaver.valid;
    chk_ready <= ready_q;
    chk_data  <= slaver.data;
  end
`else
  // protocol checks not built
`endif
endmodule

// File: tb/tb_data_c_rev_pipe.sv
// Randomized and directed bench for data_c_rev_pipe against a queue-based stream model.
module tb_data_c_rev_pipe;
  localparam int DSIZE = 8;

  logic             clock = 1'b0;
  logic             rst   = 1'b1;
  logic             s_valid = 1'b0;
  logic [DSIZE-1:0] s_data  = '0;
  logic             m_ready = 1'b0;

  data_c_rev_pipe_if #(.DSIZE(DSIZE)) s_if (.clock(clock), .rst_n(~rst));
  data_c_rev_pipe_if #(.DSIZE(DSIZE)) m_if (.clock(clock), .rst_n(~rst));

  assign s_if.valid = s_valid;
  assign s_if.data  = s_data;
  assign m_if.ready = m_ready;

  data_c_rev_pipe #(.DSIZE(DSIZE)) dut (
    .clock  (clock),
    .rst    (rst),
    .slaver (s_if),
    .master (m_if)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // stream model: beats held by the block, in order
  logic [DSIZE-1:0] q[$];
  logic             mdl_valid = 1'b0;
  logic             mdl_ready = 1'b0;
  logic             last_in   = 1'b0;
  logic             prev_stall = 1'b0;
  logic [DSIZE-1:0] prev_data  = '0;
  logic [DSIZE-1:0] dut_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle();
    logic in_hs, out_hs;
    @(negedge clock);
    chk("valid", {31'd0, m_if.valid}, {31'd0, mdl_valid});
    chk("ready", {31'd0, s_if.ready}, {31'd0, mdl_ready});
    if (mdl_valid) chk("data", {24'd0, m_if.data}, {24'd0, q[0]});
    if (prev_stall) chk("stable", {24'd0, m_if.data}, {24'd0, prev_data});
    prev_stall = m_if.valid & !m_ready & !rst;
    prev_data  = m_if.data;
    if (m_if.valid && m_ready && !rst) dut_log.push_back(m_if.data);
    @(posedge clock);
    last_in = 1'b0;
    if (rst) begin
      q.delete();
      mdl_valid = 1'b0;
      mdl_ready = 1'b0;
    end else begin
      in_hs  = s_valid & mdl_ready;
      out_hs = mdl_valid & m_ready;
      if (out_hs) void'(q.pop_front());
      if (in_hs) q.push_back(s_data);
      mdl_valid = (q.size() != 0);
      mdl_ready = (q.size() != 2);
      last_in   = in_hs;
    end
    #1;
  endtask

  task automatic send_beat(input logic [DSIZE-1:0] d, input int max_cyc);
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      if (last_in) return;
    end
    chk("send_timeout", {31'd0, last_in}, 32'd1);
  endtask

  initial begin
    int n;
    int sent;
    int base;
    logic [DSIZE-1:0] next_d;

    // reset release
    rst = 1'b1;
    repeat (3) cycle();
    chk("rst_data", {24'd0, m_if.data}, 32'd0);
    chk("rst_ready", {31'd0, s_if.ready}, 32'd0);
    rst = 1'b0;
    cycle();
    chk("rel_ready", {31'd0, s_if.ready}, 32'd1);
    chk("rel_valid", {31'd0, m_if.valid}, 32'd0);

    // streaming at full rate
    m_ready = 1'b1;
    base = dut_log.size();
    for (int i = 1; i <= 16; i++) begin
      send_beat(DSIZE'(i), 1);
      chk("lat_valid", {31'd0, m_if.valid}, 32'd1);
      chk("lat_data", {24'd0, m_if.data}, i);
    end
    s_valid = 1'b0;
    repeat (3) cycle();
    chk("stream_cnt", dut_log.size() - base, 32'd16);
    for (int i = 0; i < 16 && base + i < dut_log.size(); i++)
      chk("stream_ord", {24'd0, dut_log[base+i]}, i + 1);

    // stall and fill
    m_ready = 1'b0;
    base = dut_log.size();
    send_beat(8'hA1, 4);
    send_beat(8'hA2, 4);
    s_data = 8'hA3;
    repeat (3) cycle();
    chk("stall_ready", {31'd0, s_if.ready}, 32'd0);
    chk("stall_head", {24'd0, m_if.data}, 32'hA1);
    m_ready = 1'b1;
    for (int i = 0; i < 4 && !last_in; i++) cycle();
    chk("a3_taken", {31'd0, last_in}, 32'd1);
    s_valid = 1'b0;
    repeat (4) cycle();
    chk("stall_cnt", dut_log.size() - base, 32'd3);
    if (dut_log.size() - base == 3) begin
      chk("stall_o0", {24'd0, dut_log[base]},   32'hA1);
      chk("stall_o1", {24'd0, dut_log[base+1]}, 32'hA2);
      chk("stall_o2", {24'd0, dut_log[base+2]}, 32'hA3);
    end

    // reset with the buffer full
    m_ready = 1'b0;
    send_beat(8'h55, 4);
    send_beat(8'h66, 4);
    s_valid = 1'b0;
    cycle();
    chk("full_ready", {31'd0, s_if.ready}, 32'd0);
    n = dut_log.size();
    m_ready = 1'b1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_valid", {31'd0, m_if.valid}, 32'd0);
    chk("mid_ready", {31'd0, s_if.ready}, 32'd0);
    repeat (5) cycle();
    chk("mid_nodrop", dut_log.size(), n);

    // random valid/ready
    s_valid = 1'b0;
    last_in = 1'b0;
    sent    = 0;
    next_d  = '0;
    base    = dut_log.size();
    for (int c = 0; c < 10000 && (sent < 1000 || s_valid || q.size() != 0); c++) begin
      if (last_in) begin
        sent++;
        next_d++;
        s_valid = 1'b0;
      end
      if (!s_valid && sent < 1000 && $urandom_range(1, 0) == 1) begin
        s_valid = 1'b1;
        s_data  = next_d;
      end
      m_ready = ($urandom_range(1, 0) == 1);
      cycle();
    end
    chk("rand_sent", sent, 32'd1000);
    chk("rand_cnt", dut_log.size() - base, 32'd1000);
    for (int i = 0; i < 1000 && base + i < dut_log.size(); i++)
      chk("rand_ord", {24'd0, dut_log[base+i]}, i & 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
